// File: rtl/ni_noc_port_if.sv
// Handshake bundle between ni_noc_port and its surroundings: the NI FIFO pair and the router local port.
// The master modport is the port adapter's side. The slave modport is the FIFO/router side.
interface ni_noc_port_if #(
    parameter int DSIZE = 32
);
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic [DSIZE-1:0] inj_flit;
    logic             inj_valid;
    logic             inj_ready;
    logic [DSIZE-1:0] ej_flit;
    logic             ej_valid;
    logic             ej_ready;
    logic [DSIZE-1:0] fifo_wdata;
    logic             fifo_winc;
    logic             fifo_wfull;

    modport master (
        input  fifo_rdata, fifo_rempty, inj_ready, ej_flit, ej_valid, fifo_wfull,
        output fifo_rinc, inj_flit, inj_valid, ej_ready, fifo_wdata, fifo_winc
    );

    modport slave (
        output fifo_rdata, fifo_rempty, inj_ready, ej_flit, ej_valid, fifo_wfull,
        input  fifo_rinc, inj_flit, inj_valid, ej_ready, fifo_wdata, fifo_winc
    );
endinterface

// File: rtl/ni_noc_port.sv
// NoC-side NI port: pops the NI write FIFO into the router or a local loopback slot, and merges ejected and looped flits into the NI read FIFO.
// Latency: one cycle from pop to inj_valid or lb_valid. The read-FIFO push is combinational. NI_PORT_STATS_EN adds traffic counters.
// Backpressure: a stalled head blocks the pop path (head-of-line). fifo_wfull stalls both eject sources. Arbitration alternates on contention.
module ni_noc_port #(
    parameter int          MSB_SLOT  = 5,
    parameter logic [15:0] ROUTER_ID = 16'h0000
) (
    input  logic          noc_clk,
    input  logic          noc_rst_n,
    ni_noc_port_if.master bus
`ifdef NI_PORT_STATS_EN
    ,
    output logic [15:0]   inj_cnt,
    output logic [15:0]   ej_cnt,
    output logic [15:0]   lb_cnt
`endif
);
    localparam int DSIZE = 1 << MSB_SLOT;
    localparam int RSIZE = DSIZE / 2;
    localparam logic [RSIZE-1:0] OWN_ID = RSIZE'(ROUTER_ID);

    typedef enum logic {
        PRIO_EJ = 1'b0,
        PRIO_LB = 1'b1
    } prio_e;

    logic             run;
    prio_e            prio, prio_nxt;
    logic             inj_valid;
    logic [DSIZE-1:0] inj_flit;
    logic             lb_valid;
    logic [DSIZE-1:0] lb_flit;

    logic is_lb, arb_ok, lb_grant, ej_rdy, ej_push, contested;
    logic inj_free, lb_free, pop;

    always_comb begin
        is_lb     = (bus.fifo_rdata[DSIZE-1:RSIZE] == OWN_ID);
        arb_ok    = run & ~bus.fifo_wfull;
        lb_grant  = arb_ok & lb_valid & ~(bus.ej_valid & (prio == PRIO_EJ));
        // ej_ready depends only on local state, so the router may rely on it before asserting ej_valid
        ej_rdy    = arb_ok & (~lb_valid | (prio == PRIO_EJ));
        ej_push   = bus.ej_valid & ej_rdy;
        contested = arb_ok & lb_valid & bus.ej_valid;
        inj_free  = ~inj_valid | bus.inj_ready;
        lb_free   = ~lb_valid | lb_grant;
        pop       = run & ~bus.fifo_rempty & (is_lb ? lb_free : inj_free);
    end

    always_comb begin
        prio_nxt = prio;
        if (contested) begin
            prio_nxt = (prio == PRIO_EJ) ? PRIO_LB : PRIO_EJ;
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            run       <= 1'b0;
            prio      <= PRIO_EJ;
            inj_valid <= 1'b0;
            inj_flit  <= '0;
            lb_valid  <= 1'b0;
            lb_flit   <= '0;
        end else begin
            run  <= 1'b1;
            prio <= prio_nxt;
            if (pop && !is_lb) begin
                inj_valid <= 1'b1;
                inj_flit  <= bus.fifo_rdata;
            end else if (bus.inj_ready) begin
                inj_valid <= 1'b0;
            end
            if (pop && is_lb) begin
                lb_valid <= 1'b1;
                lb_flit  <= bus.fifo_rdata;
            end else if (lb_grant) begin
                lb_valid <= 1'b0;
            end
        end
    end

    assign bus.fifo_rinc  = pop;
    assign bus.inj_valid  = inj_valid;
    assign bus.inj_flit   = inj_flit;
    assign bus.ej_ready   = ej_rdy;
    assign bus.fifo_winc  = ej_push | lb_grant;
    assign bus.fifo_wdata = lb_grant ? lb_flit : bus.ej_flit;

`ifdef NI_PORT_STATS_EN
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            inj_cnt <= '0;
            ej_cnt  <= '0;
            lb_cnt  <= '0;
        end else begin
            if (inj_valid && bus.inj_ready) inj_cnt <= inj_cnt + 16'd1;
            if (ej_push)                    ej_cnt  <= ej_cnt + 16'd1;
            if (lb_grant)                   lb_cnt  <= lb_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ni_noc_port.sv
module tb_ni_noc_port;
    localparam logic [15:0] RID = 16'h0003;

    logic noc_clk = 1'b0;
    logic noc_rst_n = 1'b0;
    always #5 noc_clk = ~noc_clk;

    ni_noc_port_if #(.DSIZE(32)) bus ();

`ifdef NI_PORT_STATS_EN
    logic [15:0] inj_cnt, ej_cnt, lb_cnt;
`endif

    ni_noc_port #(.MSB_SLOT(5), .ROUTER_ID(RID)) dut (
        .noc_clk   (noc_clk),
        .noc_rst_n (noc_rst_n),
        .bus       (bus)
`ifdef NI_PORT_STATS_EN
        ,
        .inj_cnt   (inj_cnt),
        .ej_cnt    (ej_cnt),
        .lb_cnt    (lb_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Layout of every vector: {rinc, inj_valid, inj_flit, ej_ready, winc, wdata}
    function automatic logic [67:0] pk(input logic ri, input logic iv, input logic [31:0] fl,
                                       input logic er, input logic wi, input logic [31:0] wd);
        return {ri, iv, fl, er, wi, wd};
    endfunction

    function automatic logic [67:0] act_vec();
        return pk(bus.fifo_rinc, bus.inj_valid, bus.inj_flit, bus.ej_ready, bus.fifo_winc, bus.fifo_wdata);
    endfunction

    typedef struct {
        logic        rempty;
        logic [31:0] rdata;
        logic        inj_ready;
        logic        ej_valid;
        logic [31:0] ej_flit;
        logic        wfull;
        logic [67:0] exp;
    } vec_t;

    function automatic vec_t v(input logic re, input logic [31:0] rd, input logic ir, input logic ev,
                               input logic [31:0] ef, input logic wf, input logic ri, input logic iv,
                               input logic [31:0] fl, input logic er, input logic wi, input logic [31:0] wd);
        vec_t r;
        r.rempty = re; r.rdata = rd; r.inj_ready = ir; r.ej_valid = ev;
        r.ej_flit = ef; r.wfull = wf; r.exp = pk(ri, iv, fl, er, wi, wd);
        return r;
    endfunction

    task automatic drive(input logic re, input logic [31:0] rd, input logic ir, input logic ev,
                         input logic [31:0] ef, input logic wf);
        bus.fifo_rempty = re; bus.fifo_rdata = rd; bus.inj_ready = ir;
        bus.ej_valid = ev; bus.ej_flit = ef; bus.fifo_wfull = wf;
    endtask

    // Behavioural model: source FIFO, inject slot and loopback slot as queues
    logic [31:0] src_q[$];
    logic [31:0] m_inj[$];
    logic [31:0] m_lb[$];
    bit          m_prio_lb;
    bit          m_run;

    function automatic logic [31:0] gen_entry();
        logic [15:0] d;
        d = ($urandom_range(0, 2) == 0) ? RID : 16'($urandom_range(0, 7));
        return {d, 16'($urandom)};
    endfunction

    localparam logic [31:0] A   = 32'h0005_00AA;
    localparam logic [31:0] B   = 32'h0006_00BB;
    localparam logic [31:0] L42 = 32'h0003_0042;
    localparam logic [31:0] E9  = 32'h0009_1234;
    localparam logic [31:0] L1  = 32'h0003_0001;
    localparam logic [31:0] L2  = 32'h0003_0002;
    localparam logic [31:0] L11 = 32'h0003_0011;
    localparam logic [31:0] L22 = 32'h0003_0022;
    localparam logic [31:0] E   = 32'h0007_0E0E;

    vec_t tbl[28];

    initial begin
        //          re rdata ir ev ej_flit wf | ri iv inj_flit er wi wdata
        tbl[0]  = v(0, A,   1, 0, 32'h0, 0,   0, 0, 32'h0, 0, 0, 32'h0);
        tbl[1]  = v(0, A,   1, 0, 32'h0, 0,   1, 0, 32'h0, 1, 0, 32'h0);
        tbl[2]  = v(1, A,   1, 0, 32'h0, 0,   0, 1, A,     1, 0, 32'h0);
        tbl[3]  = v(1, A,   1, 0, 32'h0, 0,   0, 0, A,     1, 0, 32'h0);
        tbl[4]  = v(0, A,   0, 0, 32'h0, 0,   1, 0, A,     1, 0, 32'h0);
        tbl[5]  = v(0, B,   0, 0, 32'h0, 0,   0, 1, A,     1, 0, 32'h0);
        tbl[6]  = v(0, B,   0, 0, 32'h0, 0,   0, 1, A,     1, 0, 32'h0);
        tbl[7]  = v(0, B,   0, 0, 32'h0, 0,   0, 1, A,     1, 0, 32'h0);
        tbl[8]  = v(0, B,   1, 0, 32'h0, 0,   1, 1, A,     1, 0, 32'h0);
        tbl[9]  = v(1, B,   1, 0, 32'h0, 0,   0, 1, B,     1, 0, 32'h0);
        tbl[10] = v(1, B,   1, 0, 32'h0, 0,   0, 0, B,     1, 0, 32'h0);
        tbl[11] = v(0, L42, 1, 0, 32'h0, 0,   1, 0, B,     1, 0, 32'h0);
        tbl[12] = v(1, L42, 1, 0, 32'h0, 0,   0, 0, B,     1, 1, L42);
        tbl[13] = v(1, L42, 1, 0, 32'h0, 0,   0, 0, B,     1, 0, 32'h0);
        tbl[14] = v(1, 32'h0, 1, 1, E9,  1,   0, 0, B,     0, 0, E9);
        tbl[15] = v(1, 32'h0, 1, 1, E9,  0,   0, 0, B,     1, 1, E9);
        tbl[16] = v(1, 32'h0, 1, 0, E9,  0,   0, 0, B,     1, 0, E9);
        tbl[17] = v(0, L1,  1, 0, E9,    1,   1, 0, B,     0, 0, E9);
        tbl[18] = v(0, L2,  1, 0, E9,    1,   0, 0, B,     0, 0, E9);
        tbl[19] = v(0, L2,  1, 0, E9,    0,   1, 0, B,     1, 1, L1);
        tbl[20] = v(1, L2,  1, 0, E9,    0,   0, 0, B,     1, 1, L2);
        tbl[21] = v(1, L2,  1, 0, E9,    0,   0, 0, B,     1, 0, E9);
        tbl[22] = v(0, L11, 1, 1, E,     0,   1, 0, B,     1, 1, E);
        tbl[23] = v(0, L22, 1, 1, E,     0,   0, 0, B,     1, 1, E);
        tbl[24] = v(0, L22, 1, 1, E,     0,   1, 0, B,     0, 1, L11);
        tbl[25] = v(1, L22, 1, 1, E,     0,   0, 0, B,     1, 1, E);
        tbl[26] = v(1, L22, 1, 1, E,     0,   0, 0, B,     0, 1, L22);
        tbl[27] = v(1, L22, 1, 0, E,     0,   0, 0, B,     1, 0, E);

        drive(1, 32'h0, 0, 0, 32'h0, 0);
        @(negedge noc_clk);
        check("in_reset", act_vec(), pk(0, 0, 32'h0, 0, 0, 32'h0));
        @(posedge noc_clk); #1;
        noc_rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].rempty, tbl[i].rdata, tbl[i].inj_ready, tbl[i].ej_valid, tbl[i].ej_flit, tbl[i].wfull);
            @(negedge noc_clk);
            check($sformatf("vec%0d", i), act_vec(), tbl[i].exp);
            @(posedge noc_clk); #1;
        end

        // Asynchronous reset while an inject flit is stalled, then run gating on release
        drive(0, A, 0, 0, 32'h0, 0);
        @(posedge noc_clk); #1;
        check("inj_loaded", {66'h0, bus.inj_valid, bus.fifo_rinc}, {66'h0, 1'b1, 1'b0});
        #2 noc_rst_n = 1'b0;
        #1;
        check("async_rst", {35'h0, bus.inj_valid, bus.inj_flit}, {35'h0, 1'b0, 32'h0});
        @(posedge noc_clk); #1;
        noc_rst_n = 1'b1;
        #1;
        check("post_rel_rinc", {67'h0, bus.fifo_rinc}, 68'h0);
        @(posedge noc_clk); #1;
        check("run_rinc", {67'h0, bus.fifo_rinc}, 68'h1);

        // Randomised run against the queue model
        noc_rst_n = 1'b0;
        @(posedge noc_clk); #1;
        noc_rst_n = 1'b1;
        src_q.delete(); m_inj.delete(); m_lb.delete();
        m_prio_lb = 0; m_run = 0;
        for (int c = 0; c < 3000; c++) begin
            bit          can, lbr, loc, e_iv, e_rinc, e_er, contest;
            int          win;
            logic [31:0] e_wd, e_if;
            logic [67:0] a, e;
            if (src_q.size() < 4 && $urandom_range(0, 2) != 0) src_q.push_back(gen_entry());
            drive(src_q.size() == 0, (src_q.size() != 0) ? src_q[0] : 32'($urandom),
                  $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 32'($urandom),
                  $urandom_range(0, 4) == 0);
            @(negedge noc_clk);
            can     = m_run && !bus.fifo_wfull;
            lbr     = m_lb.size() != 0;
            contest = can && lbr && bus.ej_valid;
            if (contest)                  win = m_prio_lb ? 2 : 1;
            else if (can && lbr)          win = 2;
            else if (can && bus.ej_valid) win = 1;
            else                          win = 0;
            e_er   = can && (!lbr || !m_prio_lb);
            e_wd   = (win == 2) ? m_lb[0] : bus.ej_flit;
            e_iv   = m_inj.size() != 0;
            e_if   = e_iv ? m_inj[0] : 32'h0;
            loc    = (src_q.size() != 0) && (src_q[0][31:16] == RID);
            e_rinc = m_run && (src_q.size() != 0) && (loc ? (!lbr || win == 2) : (!e_iv || bus.inj_ready));
            a = pk(bus.fifo_rinc, bus.inj_valid, e_iv ? bus.inj_flit : 32'h0, bus.ej_ready,
                   bus.fifo_winc, (win != 0) ? bus.fifo_wdata : 32'h0);
            e = pk(e_rinc, e_iv, e_if, e_er, win != 0, (win != 0) ? e_wd : 32'h0);
            check($sformatf("rand%0d", c), a, e);
            @(posedge noc_clk); #1;
            if (e_iv && bus.inj_ready) void'(m_inj.pop_front());
            if (win == 2) void'(m_lb.pop_front());
            if (e_rinc) begin
                if (loc) m_lb.push_back(src_q.pop_front());
                else     m_inj.push_back(src_q.pop_front());
            end
            if (contest) m_prio_lb = !m_prio_lb;
            m_run = 1;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
